fsm_pkt_parser: RTL and testbench
=================================

// Module: fsm_pkt_parser
// PURPOSE
//  Parametrised packet-parser FSM for a word-serial stream: hunts a 2-word header,
//  reads a length word, then forwards the payload with sop/eop/vld framing.
//  Next-generation frame detector: configurable width, header and max length,
//  explicit input valid, error reporting, optional checksum.
//  Sits between a byte/word source (UART rx, test pattern gen) and downstream consumers.
// PARAMETERS
//  DATA_W   8      stream word width, >=4
//  HEAD0    8'h55  first header word (DATA_W bits)
//  HEAD1    8'hD5  second header word (DATA_W bits)
//  MAX_LEN  16     max payload words; LEN outside 1..MAX_LEN is an error
// PORTS
//  clk       in   1       clock, all logic on rising edge
//  rst       in   1       synchronous reset, active-high
//  din       in   DATA_W  input word, sampled only when din_vld=1
//  din_vld   in   1       input word valid; idle cycles allowed anywhere, FSM holds
//  dout      out  DATA_W  payload word
//  dout_vld  out  1       dout valid, payload words only
//  dout_sop  out  1       with dout_vld on first payload word
//  dout_eop  out  1       with dout_vld on last payload word
//  err       out  1       1-cycle pulse: bad length, or checksum mismatch (macro)
//  pkt_cnt   out  16      good packets completed, wraps 16'hFFFF->0
// BEHAVIOUR
//  - Reset: dout=0, dout_vld=0, dout_sop=0, dout_eop=0, err=0, pkt_cnt=0, state=IDLE, cnt=0.
//  - States: IDLE, HEAD, LEN, DATA, CHK. Transitions only on din_vld=1 cycles.
//    IDLE: din==HEAD0 -> HEAD; else stay.
//    HEAD: din==HEAD1 -> LEN; din==HEAD0 -> stay HEAD (resync); else -> IDLE.
//    LEN : din in 1..MAX_LEN -> latch len, cnt=0, -> DATA; else err pulse, -> IDLE.
//          Compare uses unsigned DATA_W-bit value; LEN=0 is an error.
//    DATA: forward word, cnt++; when cnt==len-1 -> CHK (macro) or IDLE.
//  - Outputs registered: a payload word sampled at edge N appears on dout at edge N+1
//    (1-cycle latency). dout holds last value when dout_vld=0.
//  - sop and eop both high on the same word when len=1.
//  - Header words in DATA state are payload, not resync triggers.
//  - pkt_cnt increments with dout_eop when no checksum is compiled in,
//    or on checksum match when it is; never on err.
//  - rst mid-packet: all outputs cleared next edge, FSM to IDLE, partial packet dropped
//    without eop.
//  - err and eop never share a cycle except as stated under CONFIGURATION.
//  - Counter cnt width $clog2(MAX_LEN+1); len register same width.
// CONFIGURATION
//  - Macro PKT_CHKSUM_EN:
//    defined: after last payload FSM enters CHK and expects one checksum word =
//      (LEN + sum of payload) mod 2^DATA_W. On its valid cycle: match -> pkt_cnt++,
//      mismatch -> err pulse (1 cycle after checksum sampled). Then IDLE. Payload and
//      eop still forwarded before check; consumers qualify with err.
//    undefined: no CHK state and no accumulator; DATA -> IDLE after last word;
//      err asserts only for bad LEN.
// TESTING
//  (DATA_W=8, HEAD0=55, HEAD1=D5, MAX_LEN=16)
//  - 55 D5 03 A1 A2 A3, din_vld continuous -> dout A1/A2/A3, sop with A1, eop with A3,
//    pkt_cnt=1.
//  - 55 55 D5 01 7E with din_vld gaps between words -> single-word packet 7E,
//    sop=eop=1, gaps produce no dout_vld.
//  - 55 D5 00 and 55 D5 11 -> err pulse each, no dout_vld, pkt_cnt unchanged;
//    following 55 D5 02 10 20 parses normally.
//  - rst high for 1 cycle after 55 D5 04 B1 B2 -> outputs 0 next edge, no eop;
//    next 55 D5 01 C3 -> sop+eop on C3.
//  - PKT_CHKSUM_EN: 55 D5 02 10 20 32 -> pkt_cnt+1, err=0;
//    55 D5 02 10 20 33 -> err pulse, pkt_cnt unchanged.
//  - Noise 00 FF 55 12 D5 before valid packet -> no output until real 55 D5 header.

Source files
------------

// File: rtl/fsm_pkt_parser_if.sv
// Stream bundle between a word source, the packet parser and its payload consumer.
// master: the parser side (consumes din, drives framed payload); slave: the bench/system side.
interface fsm_pkt_parser_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] din;
    logic              din_vld;
    logic [DATA_W-1:0] dout;
    logic              dout_vld;
    logic              dout_sop;
    logic              dout_eop;
    logic              err;
    logic [15:0]       pkt_cnt;

    modport master (
        input  din, din_vld,
        output dout, dout_vld, dout_sop, dout_eop, err, pkt_cnt
    );

    modport slave (
        output din, din_vld,
        input  dout, dout_vld, dout_sop, dout_eop, err, pkt_cnt
    );
endinterface

// File: rtl/fsm_pkt_parser.sv
// Word-serial packet parser: hunts HEAD0/HEAD1, reads a length word, forwards payload framed
// with sop/eop. Optional trailing checksum word is enabled by defining PKT_CHKSUM_EN.
module fsm_pkt_parser #(
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] HEAD0   = DATA_W'(8'h55),
    parameter logic [DATA_W-1:0] HEAD1   = DATA_W'(8'hD5),
    parameter int unsigned       MAX_LEN = 16
) (
    input  logic                clk,
    input  logic                rst,
    fsm_pkt_parser_if.master    bus
);
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam logic [DATA_W-1:0] MAX_W = DATA_W'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE,
        HEAD,
        LEN,
`ifdef PKT_CHKSUM_EN
        DATA,
        CHK
`else
        DATA
`endif
    } state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [CW-1:0]     len_reg, len_next;
    logic [DATA_W-1:0] dout_reg, dout_next;
    logic              vld_reg, vld_next;
    logic              sop_reg, sop_next;
    logic              eop_reg, eop_next;
    logic              err_reg, err_next;
    logic [15:0]       pkt_cnt_reg, pkt_cnt_next;
`ifdef PKT_CHKSUM_EN
    logic [DATA_W-1:0] sum_reg, sum_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            len_reg     <= '0;
            dout_reg    <= '0;
            vld_reg     <= 1'b0;
            sop_reg     <= 1'b0;
            eop_reg     <= 1'b0;
            err_reg     <= 1'b0;
            pkt_cnt_reg <= '0;
`ifdef PKT_CHKSUM_EN
            sum_reg     <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            len_reg     <= len_next;
            dout_reg    <= dout_next;
            vld_reg     <= vld_next;
            sop_reg     <= sop_next;
            eop_reg     <= eop_next;
            err_reg     <= err_next;
            pkt_cnt_reg <= pkt_cnt_next;
`ifdef PKT_CHKSUM_EN
            sum_reg     <= sum_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        len_next     = len_reg;
        dout_next    = dout_reg;
        vld_next     = 1'b0;
        sop_next     = 1'b0;
        eop_next     = 1'b0;
        err_next     = 1'b0;
        pkt_cnt_next = pkt_cnt_reg;
`ifdef PKT_CHKSUM_EN
        sum_next     = sum_reg;
`endif
        // Idle cycles (din_vld=0) leave every piece of state untouched.
        if (bus.din_vld) begin
            case (state_reg)
                IDLE: begin
                    if (bus.din == HEAD0) state_next = HEAD;
                end
                HEAD: begin
                    if (bus.din == HEAD1)      state_next = LEN;
                    else if (bus.din == HEAD0) state_next = HEAD;
                    else                       state_next = IDLE;
                end
                LEN: begin
                    if (bus.din != '0 && bus.din <= MAX_W) begin
                        len_next   = CW'(bus.din);
                        cnt_next   = '0;
                        state_next = DATA;
`ifdef PKT_CHKSUM_EN
                        sum_next   = bus.din;
`endif
                    end else begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end
                end
                DATA: begin
                    dout_next = bus.din;
                    vld_next  = 1'b1;
                    sop_next  = (cnt_reg == '0);
                    cnt_next  = cnt_reg + CW'(1);
`ifdef PKT_CHKSUM_EN
                    sum_next  = sum_reg + bus.din;
`endif
                    if (cnt_reg == len_reg - CW'(1)) begin
                        eop_next = 1'b1;
`ifdef PKT_CHKSUM_EN
                        state_next = CHK;
`else
                        state_next   = IDLE;
                        pkt_cnt_next = pkt_cnt_reg + 16'd1;
`endif
                    end
                end
`ifdef PKT_CHKSUM_EN
                CHK: begin
                    if (bus.din == sum_reg) pkt_cnt_next = pkt_cnt_reg + 16'd1;
                    else                    err_next     = 1'b1;
                    state_next = IDLE;
                end
`endif
                default: state_next = IDLE;
            endcase
        end
    end

    assign bus.dout     = dout_reg;
    assign bus.dout_vld = vld_reg;
    assign bus.dout_sop = sop_reg;
    assign bus.dout_eop = eop_reg;
    assign bus.err      = err_reg;
    assign bus.pkt_cnt  = pkt_cnt_reg;
endmodule

// File: tb/tb_fsm_pkt_parser.sv
// Directed bench for fsm_pkt_parser (DATA_W=8, HEAD 55/D5, MAX_LEN=16); follows PKT_CHKSUM_EN.
module tb_fsm_pkt_parser;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0]  exp_dout = 8'h00;
    logic [15:0] exp_pkt  = 16'd0;

    always #5 clk = ~clk;

    fsm_pkt_parser_if #(.DATA_W(8)) bus ();

    fsm_pkt_parser #(
        .DATA_W (8),
        .HEAD0  (8'h55),
        .HEAD1  (8'hD5),
        .MAX_LEN(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one word (valid or idle) and check the registered outputs after the edge.
    task automatic xfer(input logic [7:0] w, input logic v, input logic ev,
                        input logic es, input logic ee, input logic er);
        @(negedge clk);
        bus.din     = w;
        bus.din_vld = v;
        @(posedge clk);
        #1;
        if (ev) exp_dout = w;
        $display("xfer din=%h vld=%b -> dout=%h vld=%b sop=%b eop=%b err=%b pkt=%0d",
                 w, v, bus.dout, bus.dout_vld, bus.dout_sop, bus.dout_eop, bus.err, bus.pkt_cnt);
        check("dout_vld", 32'(bus.dout_vld), 32'(ev));
        check("dout_sop", 32'(bus.dout_sop), 32'(es));
        check("dout_eop", 32'(bus.dout_eop), 32'(ee));
        check("err",      32'(bus.err),      32'(er));
        check("dout",     32'(bus.dout),     32'(exp_dout));
    endtask

    task automatic idle();
        xfer(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Well-formed packet: header, length, payload, and checksum word when compiled in.
    task automatic good_pkt(input logic [7:0] pl[$]);
        logic [7:0] sum;
        int n;
        n   = pl.size();
        sum = 8'(n);
        xfer(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(8'hD5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(8'(n), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            xfer(pl[i], 1'b1, 1'b1, i == 0, i == n - 1, 1'b0);
            sum = sum + pl[i];
        end
`ifdef PKT_CHKSUM_EN
        xfer(sum, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
        exp_pkt = exp_pkt + 16'd1;
        check("pkt_cnt", 32'(bus.pkt_cnt), 32'(exp_pkt));
    endtask

    initial begin
        logic [7:0] q[$];
        rst         = 1'b1;
        bus.din     = 8'h00;
        bus.din_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout_vld", 32'(bus.dout_vld), 32'd0);
        check("rst_dout",     32'(bus.dout),     32'd0);
        check("rst_err",      32'(bus.err),      32'd0);
        check("rst_pkt_cnt",  32'(bus.pkt_cnt),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic 3-word packet, continuous valid
        q = '{8'hA1, 8'hA2, 8'hA3};
        good_pkt(q);
        idle();

        // Resync on repeated 55, with idle gaps everywhere
        xfer(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); idle();
        xfer(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); idle();
        xfer(8'hD5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); idle();
        xfer(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); idle();
        xfer(8'h7E, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); idle();
`ifdef PKT_CHKSUM_EN
        xfer(8'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
        exp_pkt = exp_pkt + 16'd1;
        check("pkt_cnt_gaps", 32'(bus.pkt_cnt), 32'(exp_pkt));

        // Bad lengths 0 and MAX_LEN+1
        xfer(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(8'hD5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        xfer(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(8'hD5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("pkt_cnt_badlen", 32'(bus.pkt_cnt), 32'(exp_pkt));
        q = '{8'h10, 8'h20};
        good_pkt(q);

        // Reset mid-packet drops it without eop and clears the counter
        xfer(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(8'hD5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(8'hB1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        xfer(8'hB2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst         = 1'b1;
        bus.din_vld = 1'b0;
        @(posedge clk);
        #1;
        exp_dout = 8'h00;
        exp_pkt  = 16'd0;
        check("midrst_dout_vld", 32'(bus.dout_vld), 32'd0);
        check("midrst_dout_eop", 32'(bus.dout_eop), 32'd0);
        check("midrst_dout",     32'(bus.dout),     32'd0);
        check("midrst_pkt_cnt",  32'(bus.pkt_cnt),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        q = '{8'hC3};
        good_pkt(q);

`ifdef PKT_CHKSUM_EN
        // Checksum mismatch: err one cycle after the checksum word, no count
        xfer(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(8'hD5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(8'h10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        xfer(8'h20, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        xfer(8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("pkt_cnt_badsum", 32'(bus.pkt_cnt), 32'(exp_pkt));
        q = '{8'h10, 8'h20};
        good_pkt(q);
`endif

        // Noise before a packet whose payload contains header words
        xfer(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        xfer(8'hD5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        q = '{8'h55, 8'hD5};
        good_pkt(q);

        // Maximum length packet
        q = {};
        for (int i = 0; i < 16; i++) q.push_back(8'(8'h80 + i));
        good_pkt(q);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
